// File: rtl/flt_onboard_pkg.sv
// Shared definitions for the on-board float-core stimulus/pairing block.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
// Contents: run FSM state encoding, Galois LFSR tap constant, LFSR step function.
package flt_onboard_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam int GEN_W = 32;

   // Right-shifting Galois form of x^32 + x^22 + x^2 + x + 1:
   // the x^32 term becomes bit 31, x^22 bit 21, x^2 bit 1, x^1 bit 0.
   localparam logic [GEN_W-1:0] LFSR_TAPS = 32'h8020_0003;

   function automatic logic [GEN_W-1:0] lfsr_step(input logic [GEN_W-1:0] s);
      return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
   endfunction

endpackage

// File: rtl/flt_onboard_sync_fifo.sv
// Single-clock FIFO holding stimulus words that are in flight through the core.
// Latency: push visible at the head one cycle later; head is read combinationally.
// Backpressure: pushes while full and pops while empty are ignored; simultaneous push/pop keeps count.
// Ports: i_aclk/i_areset, i_push/i_push_dat, i_pop/o_pop_dat, o_count, o_full, o_empty.
module flt_onboard_sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 16
) (
   input  logic                           i_aclk,
   input  logic                           i_areset,
   input  logic                           i_push,
   input  logic [WIDTH-1:0]               i_push_dat,
   input  logic                           i_pop,
   output logic [WIDTH-1:0]               o_pop_dat,
   output logic [$clog2(DEPTH+1)-1:0]     o_count,
   output logic                           o_full,
   output logic                           o_empty
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign o_full    = (o_count == CW'(DEPTH));
   assign o_empty   = (o_count == '0);
   assign do_push   = i_push && !o_full;
   assign do_pop    = i_pop && !o_empty;
   assign o_pop_dat = mem[rd_ptr];

   // Storage carries no reset: only entries below o_count are ever read.
   always_ff @(posedge i_aclk) begin
      if (do_push) begin
         mem[wr_ptr] <= i_push_dat;
      end
   end

   // DEPTH is a power of two, so pointers wrap naturally.
   always_ff @(posedge i_aclk or posedge i_areset) begin
      if (i_areset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         o_count <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   o_count <= o_count + CW'(1);
            2'b01:   o_count <= o_count - CW'(1);
            default: o_count <= o_count;
         endcase
      end
   end

endmodule

// File: rtl/flt_onboard_stim_pair.sv
// Drives a stimulus stream into a float core and pairs each result with the word that produced it.
// Latency: result transfer -> o_pair_tvalid one cycle later; stimulus valid is combinational from state.
// Backpressure: holds stimulus while i_axi4s_a_tready is low; stops issuing when FIFO_DEPTH words are in flight.
// Ports: i_aclk/i_areset, i_start/o_busy/o_done run control, o_axi4s_a_* stimulus stream,
//        i_axi4s_result_* result stream, o_pair_* aligned pairs, o_sent_cnt/o_recv_cnt/o_underflow_err status.
module flt_onboard_stim_pair
   import flt_onboard_pkg::*;
#(
   parameter int          TDATA_WIDTH     = 32,
   parameter int          TDATA_OUT_WIDTH = 32,
   parameter int          NUM_VECTORS     = 1024,
   parameter int          FIFO_DEPTH      = 16,
   parameter int          MODE            = 0,
   parameter logic [31:0] LFSR_SEED       = 32'h0000_0001
) (
   input  logic                               i_aclk,
   input  logic                               i_areset,
   input  logic                               i_start,
   output logic                               o_busy,
   output logic                               o_done,
   output logic [TDATA_WIDTH-1:0]             o_axi4s_a_tdata,
   output logic                               o_axi4s_a_tvalid,
   input  logic                               i_axi4s_a_tready,
   input  logic [TDATA_OUT_WIDTH-1:0]         i_axi4s_result_tdata,
   input  logic                               i_axi4s_result_tvalid,
   output logic                               o_axi4s_result_tready,
   output logic [TDATA_WIDTH-1:0]             o_pair_a_tdata,
   output logic [TDATA_OUT_WIDTH-1:0]         o_pair_result_tdata,
   output logic                               o_pair_tvalid,
   output logic [$clog2(NUM_VECTORS+1)-1:0]   o_sent_cnt,
   output logic [$clog2(NUM_VECTORS+1)-1:0]   o_recv_cnt,
   output logic                               o_underflow_err
);
   localparam int CW    = $clog2(NUM_VECTORS+1);
   localparam int FCW   = $clog2(FIFO_DEPTH+1);
   localparam int EXT_W = (TDATA_WIDTH > GEN_W) ? TDATA_WIDTH : GEN_W;
   localparam logic [GEN_W-1:0] GEN_INIT = (MODE == 1) ? LFSR_SEED : '0;

   state_t            state;
   state_t            state_nxt;
   logic [GEN_W-1:0]  gen;
   logic [EXT_W-1:0]  gen_ext;
   logic              start_acc;
   logic              a_xfer;
   logic              r_xfer;
   logic              pop;
   logic              underflow_evt;
   logic              fifo_room;
   logic [TDATA_WIDTH-1:0] fifo_head;
   logic [FCW-1:0]    fifo_cnt;
   logic              fifo_full;
   logic              fifo_empty;

   assign start_acc     = i_start && ((state == ST_IDLE) || (state == ST_DONE));
   assign fifo_room     = !fifo_full && (fifo_cnt < FCW'(FIFO_DEPTH));
   assign a_xfer        = o_axi4s_a_tvalid && i_axi4s_a_tready;
   assign r_xfer        = i_axi4s_result_tvalid && o_axi4s_result_tready;
   assign pop           = r_xfer && !fifo_empty;
   assign underflow_evt = r_xfer && fifo_empty;

   // Zero-extend or truncate the 32-bit generator; data is zero whenever not offered.
   assign gen_ext         = EXT_W'(gen);
   assign o_axi4s_a_tdata = o_axi4s_a_tvalid ? gen_ext[TDATA_WIDTH-1:0] : '0;

   // State register
   always_ff @(posedge i_aclk or posedge i_areset) begin
      if (i_areset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE, ST_DONE: if (i_start) state_nxt = ST_RUN;
         ST_RUN:           if (o_sent_cnt == CW'(NUM_VECTORS)) state_nxt = ST_DRAIN;
         ST_DRAIN:         if (o_recv_cnt == CW'(NUM_VECTORS)) state_nxt = ST_DONE;
         default:          state_nxt = ST_IDLE;
      endcase
   end

   // Output decode
   always_comb begin
      o_busy                = 1'b0;
      o_done                = 1'b0;
      o_axi4s_result_tready = 1'b0;
      o_axi4s_a_tvalid      = 1'b0;
      case (state)
         ST_RUN: begin
            o_busy                = 1'b1;
            o_axi4s_result_tready = 1'b1;
            o_axi4s_a_tvalid      = (o_sent_cnt < CW'(NUM_VECTORS)) && fifo_room;
         end
         ST_DRAIN: begin
            o_busy                = 1'b1;
            o_axi4s_result_tready = 1'b1;
         end
         ST_DONE: o_done = 1'b1;
         default: ;
      endcase
   end

   // Generator, counters, sticky error and pair register.
   // A start is only accepted in IDLE/DONE where both streams are idle,
   // so it never coincides with a transfer.
   always_ff @(posedge i_aclk or posedge i_areset) begin
      if (i_areset) begin
         gen                 <= GEN_INIT;
         o_sent_cnt          <= '0;
         o_recv_cnt          <= '0;
         o_underflow_err     <= 1'b0;
         o_pair_a_tdata      <= '0;
         o_pair_result_tdata <= '0;
         o_pair_tvalid       <= 1'b0;
      end else begin
         o_pair_tvalid <= pop;
         if (pop) begin
            o_pair_a_tdata      <= fifo_head;
            o_pair_result_tdata <= i_axi4s_result_tdata;
         end
         if (start_acc) begin
            gen             <= GEN_INIT;
            o_sent_cnt      <= '0;
            o_recv_cnt      <= '0;
            o_underflow_err <= 1'b0;
         end else begin
            if (a_xfer) begin
               gen        <= (MODE == 1) ? lfsr_step(gen) : gen + 32'd1;
               o_sent_cnt <= o_sent_cnt + CW'(1);
            end
            if (pop) begin
               o_recv_cnt <= o_recv_cnt + CW'(1);
            end
            if (underflow_evt) begin
               o_underflow_err <= 1'b1;
            end
         end
      end
   end

   flt_onboard_sync_fifo #(
      .WIDTH (TDATA_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_inflight (
      .i_aclk     (i_aclk),
      .i_areset   (i_areset),
      .i_push     (a_xfer),
      .i_push_dat (o_axi4s_a_tdata),
      .i_pop      (pop),
      .o_pop_dat  (fifo_head),
      .o_count    (fifo_cnt),
      .o_full     (fifo_full),
      .o_empty    (fifo_empty)
   );

endmodule

// File: tb/tb_flt_onboard_stim_pair.sv
// Bench for flt_onboard_stim_pair: a counter instance and an LFSR instance share one
// stimulus/result harness; a latency-programmable core model answers the counter instance.
module tb_flt_onboard_stim_pair;
   localparam int NV  = 8;
   localparam int DEP = 4;
   localparam int CW  = $clog2(NV+1);

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] r;
   } pair_t;

   typedef struct {
      int rdy;        // 0 always ready, 1 toggling, 2 never ready
      int lat;        // core latency in cycles
      int hold;       // cycles the core withholds results after start
      bit start_mid;  // extra i_start while running (must be ignored)
      int exp_sent;
      int exp_recv;
   } scn_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, start, a_rdy, r_vld;
   logic [31:0] r_dat;

   logic busy0, done0, a_vld0, r_rdy0, pv0, uf0;
   logic busy1, done1, a_vld1, r_rdy1, pv1, uf1;
   logic [31:0] a_dat0, pa0, pr0, a_dat1, pa1, pr1;
   logic [CW-1:0] sent0, recv0, sent1, recv1;

   flt_onboard_stim_pair #(.TDATA_WIDTH(32), .TDATA_OUT_WIDTH(32), .NUM_VECTORS(NV),
                           .FIFO_DEPTH(DEP), .MODE(0), .LFSR_SEED(32'h1)) dut0 (
      .i_aclk(clk), .i_areset(rst), .i_start(start), .o_busy(busy0), .o_done(done0),
      .o_axi4s_a_tdata(a_dat0), .o_axi4s_a_tvalid(a_vld0), .i_axi4s_a_tready(a_rdy),
      .i_axi4s_result_tdata(r_dat), .i_axi4s_result_tvalid(r_vld), .o_axi4s_result_tready(r_rdy0),
      .o_pair_a_tdata(pa0), .o_pair_result_tdata(pr0), .o_pair_tvalid(pv0),
      .o_sent_cnt(sent0), .o_recv_cnt(recv0), .o_underflow_err(uf0));

   flt_onboard_stim_pair #(.TDATA_WIDTH(32), .TDATA_OUT_WIDTH(32), .NUM_VECTORS(NV),
                           .FIFO_DEPTH(DEP), .MODE(1), .LFSR_SEED(32'h1)) dut1 (
      .i_aclk(clk), .i_areset(rst), .i_start(start), .o_busy(busy1), .o_done(done1),
      .o_axi4s_a_tdata(a_dat1), .o_axi4s_a_tvalid(a_vld1), .i_axi4s_a_tready(a_rdy),
      .i_axi4s_result_tdata(r_dat), .i_axi4s_result_tvalid(r_vld), .o_axi4s_result_tready(r_rdy1),
      .o_pair_a_tdata(pa1), .o_pair_result_tdata(pr1), .o_pair_tvalid(pv1),
      .o_sent_cnt(sent1), .o_recv_cnt(recv1), .o_underflow_err(uf1));

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   int rdy_mode = 0;
   int lat = 5;
   int hold_cnt = 0;
   bit start_req = 0;
   bit spur_req = 0;
   bit prev_stall = 0;
   logic [31:0] prev_dat = '0;
   logic [31:0] exp_a0 = '0;
   logic [31:0] exp_a1 = 32'h1;
   int pairs_seen = 0;
   int pair8_cyc = -1;
   int lfsr_idx = 0;

   pair_t exp0_q[$];
   pair_t exp1_q[$];
   logic [31:0] core_a_q[$];
   int core_due_q[$];

   logic [31:0] lfsr_gold [3] = '{32'h0000_0001, 32'h8020_0003, 32'hC030_0002};
   scn_t scns [5];

   function automatic logic [31:0] core_f(input logic [31:0] a);
      return (a * 32'd3) ^ 32'h5A5A_0F0F;
   endfunction

   function automatic logic [31:0] lfsr_next(input logic [31:0] s);
      return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // One clock: observe after the edge, drive the next cycle's inputs, then log transfers.
   task automatic tick();
      pair_t e;
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (pv0) begin
         if (exp0_q.size() == 0) chk("unexpected_pair", 64'(pv0), 64'd0);
         else begin
            e = exp0_q.pop_front();
            chk("pair_a", pa0, e.a);
            chk("pair_result", pr0, e.r);
            pairs_seen++;
            if (pairs_seen == NV) pair8_cyc = cyc;
         end
      end
      if (pv1) begin
         if (exp1_q.size() == 0) chk("unexpected_pair_lfsr", 64'(pv1), 64'd0);
         else begin
            e = exp1_q.pop_front();
            chk("pair_a_lfsr", pa1, e.a);
            chk("pair_result_lfsr", pr1, e.r);
            if (lfsr_idx < 3) chk("lfsr_golden", pa1, lfsr_gold[lfsr_idx]);
            lfsr_idx++;
         end
      end
      if (prev_stall) begin
         chk("stall_hold_vld", 64'(a_vld0), 64'd1);
         chk("stall_hold_dat", a_dat0, prev_dat);
      end
      start = start_req;
      start_req = 0;
      case (rdy_mode)
         0:       a_rdy = 1'b1;
         1:       a_rdy = cyc[0];
         default: a_rdy = 1'b0;
      endcase
      if (spur_req) begin
         r_vld = 1'b1;
         r_dat = 32'hDEAD_BEEF;
      end else if (hold_cnt > 0) begin
         r_vld = 1'b0;
         hold_cnt--;
      end else if (core_a_q.size() > 0 && core_due_q[0] <= cyc) begin
         r_vld = 1'b1;
         r_dat = core_f(core_a_q[0]);
      end else begin
         r_vld = 1'b0;
      end
      #1;
      prev_stall = a_vld0 && !a_rdy;
      prev_dat   = a_dat0;
      if (a_vld0 && a_rdy) begin
         chk("a_word", a_dat0, exp_a0);
         chk("a_word_lfsr", a_dat1, exp_a1);
         exp0_q.push_back('{exp_a0, core_f(exp_a0)});
         exp1_q.push_back('{exp_a1, core_f(exp_a0)});
         core_a_q.push_back(a_dat0);
         core_due_q.push_back(cyc + lat);
         exp_a0 = exp_a0 + 32'd1;
         exp_a1 = lfsr_next(exp_a1);
      end
      if (spur_req) spur_req = 0;
      else if (r_vld && r_rdy0) begin
         void'(core_a_q.pop_front());
         void'(core_due_q.pop_front());
      end
   endtask

   task automatic do_start();
      start_req  = 1;
      exp_a0     = '0;
      exp_a1     = 32'h1;
      pairs_seen = 0;
      lfsr_idx   = 0;
      pair8_cyc  = -1;
   endtask

   task automatic run_scn(input scn_t s);
      int n;
      int done_cyc;
      bit done_seen;
      n = 0;
      done_cyc = -1;
      done_seen = 0;
      rdy_mode = s.rdy;
      lat = s.lat;
      hold_cnt = s.hold;
      do_start();
      tick();
      while (!done_seen && n < 400) begin
         if (s.start_mid && n == 6) start_req = 1;
         tick();
         n++;
         if (s.hold > 0 && n == 15) begin
            chk("held_sent_cnt", 64'(sent0), 64'(DEP));
            chk("held_a_tvalid", 64'(a_vld0), 64'd0);
            chk("held_recv_cnt", 64'(recv0), 64'd0);
         end
         if (done0) begin
            done_seen = 1;
            done_cyc = cyc;
         end
      end
      if (!done_seen) chk("run_timeout", 64'(done0), 64'd1);
      else begin
         chk("done_after_last_pair", 64'(done_cyc - pair8_cyc), 64'd1);
         chk("sent_cnt", 64'(sent0), 64'(s.exp_sent));
         chk("recv_cnt", 64'(recv0), 64'(s.exp_recv));
         chk("pairs_seen", 64'(pairs_seen), 64'(s.exp_recv));
         chk("busy_done", 64'(busy0), 64'd0);
         chk("underflow", 64'(uf0), 64'd0);
         chk("result_tready_done", 64'(r_rdy0), 64'd0);
         chk("lfsr_done", 64'(done1), 64'd1);
         chk("scoreboard_empty", 64'(exp0_q.size()), 64'd0);
      end
   endtask

   initial begin
      int n;
      scns[0] = '{rdy: 0, lat: 5, hold: 0,  start_mid: 0, exp_sent: NV, exp_recv: NV};
      scns[1] = '{rdy: 1, lat: 5, hold: 0,  start_mid: 0, exp_sent: NV, exp_recv: NV};
      scns[2] = '{rdy: 0, lat: 1, hold: 0,  start_mid: 1, exp_sent: NV, exp_recv: NV};
      scns[3] = '{rdy: 0, lat: 5, hold: 20, start_mid: 0, exp_sent: NV, exp_recv: NV};
      scns[4] = '{rdy: 1, lat: 2, hold: 0,  start_mid: 1, exp_sent: NV, exp_recv: NV};

      rst = 1'b1; start = 1'b0; a_rdy = 1'b0; r_vld = 1'b0; r_dat = '0;
      #3;
      chk("rst_busy", 64'(busy0), 64'd0);
      chk("rst_done", 64'(done0), 64'd0);
      chk("rst_a_tvalid", 64'(a_vld0), 64'd0);
      chk("rst_a_tdata_lfsr", a_dat1, 64'd0);
      chk("rst_sent", 64'(sent0), 64'd0);
      chk("rst_recv", 64'(recv0), 64'd0);
      chk("rst_underflow", 64'(uf0), 64'd0);
      chk("rst_pair_vld", 64'(pv0), 64'd0);
      chk("rst_result_tready", 64'(r_rdy0), 64'd0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 5; i++) run_scn(scns[i]);

      // Spurious result in RUN before anything was pushed.
      rdy_mode = 2; lat = 5; hold_cnt = 0;
      do_start();
      tick(); tick(); tick();
      chk("spur_pre_busy", 64'(busy0), 64'd1);
      spur_req = 1;
      tick();
      tick();
      chk("spur_underflow", 64'(uf0), 64'd1);
      chk("spur_underflow_lfsr", 64'(uf1), 64'd1);
      chk("spur_recv", 64'(recv0), 64'd0);
      chk("spur_no_pair", 64'(pv0), 64'd0);
      chk("spur_sent", 64'(sent0), 64'd0);

      // Let the same run send three words, then reset mid-RUN.
      rdy_mode = 0; lat = 40;
      n = 0;
      while (sent0 != CW'(3) && n < 20) begin
         tick();
         n++;
      end
      chk("reach_sent3", 64'(sent0), 64'd3);
      rst = 1'b1;
      #1;
      chk("mid_rst_busy", 64'(busy0), 64'd0);
      chk("mid_rst_a_tvalid", 64'(a_vld0), 64'd0);
      chk("mid_rst_a_tdata", a_dat0, 64'd0);
      chk("mid_rst_sent", 64'(sent0), 64'd0);
      chk("mid_rst_underflow", 64'(uf0), 64'd0);
      chk("mid_rst_pair_a", pa0, 64'd0);
      chk("mid_rst_pair_result", pr0, 64'd0);
      chk("mid_rst_result_tready", 64'(r_rdy0), 64'd0);
      chk("mid_rst_lfsr_tdata", a_dat1, 64'd0);
      exp0_q.delete(); exp1_q.delete(); core_a_q.delete(); core_due_q.delete();
      prev_stall = 0;
      #2;
      rst = 1'b0;

      // A result arriving in IDLE must be discarded.
      spur_req = 1;
      tick();
      tick();
      chk("idle_result_underflow", 64'(uf0), 64'd0);
      chk("idle_result_no_pair", 64'(pv0), 64'd0);

      // Restart after reset: must begin again at a = 0.
      run_scn(scns[0]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/flt_onboard_stim_pair.md
FLT_ONBOARD_STIM_PAIR -- requirements
Module: flt_onboard_stim_pair

Interface
REQ-001 SHALL have parameter TDATA_WIDTH, default 32, stimulus bus width into the float core.
REQ-002 SHALL have parameter TDATA_OUT_WIDTH, default 32, result bus width from the float core.
REQ-003 SHALL have parameter NUM_VECTORS, default 1024, stimulus words per run (>=1).
REQ-004 SHALL have parameter FIFO_DEPTH, default 16, maximum in-flight vectors (power of 2, >=2).
REQ-005 SHALL have parameter MODE, default 0, stimulus source: 0 incrementing counter from 0, 1 Galois LFSR.
REQ-006 SHALL have parameter LFSR_SEED, default 32'h0000_0001, LFSR load value (nonzero).
REQ-007 SHALL have ports: i_aclk in 1 clock; i_areset in 1 reset (asynchronous, active-high).
REQ-008 SHALL have ports: i_start in 1 run request pulse; o_busy out 1 run active; o_done out 1 run complete.
REQ-009 SHALL have ports: o_axi4s_a_tdata out TDATA_WIDTH, o_axi4s_a_tvalid out 1, i_axi4s_a_tready in 1 (stimulus to core).
REQ-010 SHALL have ports: i_axi4s_result_tdata in TDATA_OUT_WIDTH, i_axi4s_result_tvalid in 1, o_axi4s_result_tready out 1 (result from core).
REQ-011 SHALL have ports: o_pair_a_tdata out TDATA_WIDTH, o_pair_result_tdata out TDATA_OUT_WIDTH, o_pair_tvalid out 1 (aligned input/result pair).
REQ-012 SHALL have ports: o_sent_cnt, o_recv_cnt out $clog2(NUM_VECTORS+1) each; o_underflow_err out 1 sticky.

Function
REQ-013 SHALL implement FSM IDLE, RUN, DRAIN, DONE; i_start in IDLE or DONE -> RUN, clears counters/error, reloads generator; i_start in RUN/DRAIN ignored.
REQ-014 SHALL go RUN -> DRAIN the cycle after sent count reaches NUM_VECTORS, and DRAIN -> DONE the cycle after recv count reaches NUM_VECTORS.
REQ-015 SHALL drive o_busy=1 in RUN/DRAIN and o_done=1 only in DONE, held until next i_start.
REQ-016 SHALL assert o_axi4s_a_tvalid only in RUN with sent<NUM_VECTORS and FIFO occupancy<FIFO_DEPTH.
REQ-017 SHALL hold o_axi4s_a_tdata stable and tvalid high while tvalid&&!tready; generator advances only on transfer.
REQ-018 SHALL zero-extend/truncate generator value (32 bits) to TDATA_WIDTH; counter wraps modulo 2^32; LFSR polynomial x^32+x^22+x^2+x+1.
REQ-019 SHALL push o_axi4s_a_tdata into the in-flight FIFO on every stimulus transfer.
REQ-020 SHALL hold o_axi4s_result_tready=1 in RUN/DRAIN, 0 otherwise; results in IDLE/DONE are discarded.
REQ-021 SHALL, on result transfer with FIFO non-empty, pop FIFO and present {popped input, result} on pair outputs with o_pair_tvalid high exactly 1 cycle later.
REQ-022 SHALL, on result transfer with FIFO empty, set o_underflow_err, emit no pair, not increment o_recv_cnt.
REQ-023 SHALL allow simultaneous push and pop, occupancy unchanged, including at occupancy FIFO_DEPTH-1 and 1.
REQ-024 SHALL keep pair outputs at last value when o_pair_tvalid=0.

Reset
REQ-025 SHALL on i_areset asynchronously force: state IDLE, all valids 0, counters 0, FIFO empty, o_underflow_err 0, data outputs 0, generator to 0 (MODE 0) or LFSR_SEED (MODE 1).
REQ-026 SHALL on reset mid-RUN/DRAIN abandon in-flight vectors; post-reset results are discarded in IDLE.

Structure
REQ-027 SHALL place FSM state encoding and the LFSR polynomial/tap constant in shared package flt_onboard_pkg.
REQ-028 SHALL implement the in-flight store as sub-module flt_onboard_sync_fifo (parametrised width/depth, count, full/empty).

Verification
REQ-029 MODE 0, NUM_VECTORS=8, tready=1, core latency 5 -> pairs with a=0..7 in order, o_done after 8th pair, counts 8/8.
REQ-030 tready toggled 1-0-1 per cycle -> each a word held across stall, no duplicates/skips, 8 pairs a=0..7.
REQ-031 FIFO_DEPTH=4, core withholding results 20 cycles -> sent_cnt stops at 4, tvalid low until first result returns.
REQ-032 Spurious result_tvalid in RUN before any push -> o_underflow_err=1, recv_cnt 0, no pair pulse.
REQ-033 MODE 1, seed 1 -> first three a words 0x00000001, 0x80200003, 0xC0300002 (match golden LFSR model).
REQ-034 i_areset asserted at sent_cnt=3 in RUN -> all outputs 0 same cycle, IDLE, restart via i_start yields a=0 first.
